fir_smpl_seq: RTL and testbench

Sample sequencer that drives the FIR MAC core from the input-sample side. Stores the most recent NUM_TAPS input samples in a circular history buffer. On each new sample it raises `sequencing` and streams the history, newest first, on `smpl_in`, in lockstep with the core's coefficient pointer. Sits between the audio sample source and the FIR core; one instance per filter channel.

---
 rtl/fir_smpl_seq.sv | 132 +++++++++++++
 tb/tb_fir_smpl_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_smpl_seq.sv
// Sample-side sequencer for the FIR MAC core: keeps a circular history of the
// last NUM_TAPS samples and streams it newest-first, once for each new sample.
//
// state | meaning
// IDLE  | waiting for a new or pending sample; writes it into history
// SEQ   | MAC pass, k = 0..NUM_TAPS+1 (clear, taps, flt_done)
// END   | one cycle with seq_done, lets the core drop back to idle
module fir_smpl_seq #(
  parameter int NUM_TAPS = 1021,
  parameter int PTR_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               smpl_vld,
  input  logic signed [15:0] smpl_wr,
  output logic               sequencing,
  output logic signed [15:0] smpl_in,
  output logic               seq_done,
  output logic               busy,
  output logic               ovr
);

  localparam int K_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_TAPS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_TAPS + 1);
  localparam logic [K_W-1:0]   FILL_MAX = K_W'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, SEQ, END} state_t;

  state_t state, state_nxt;

  logic signed [15:0] mem [NUM_TAPS];
  logic        [PTR_W-1:0] wr_ptr;
  logic        [PTR_W-1:0] rd_ptr;
  logic        [K_W-1:0]   fill;
  logic        [K_W-1:0]   k;
  logic                    pend_vld;
  logic signed [15:0]      pend_dat;
  logic signed [15:0]      rd_q;
  logic                    rd_en_q;

  logic                    wr_en;
  logic signed [15:0]      wr_dat;
  logic                    pend_load;
  logic                    pend_clr;
  logic                    ovr_set;
  logic                    rd_en_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_dat    = smpl_wr;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    ovr_set   = 1'b0;
    rd_en_nxt = 1'b0;
    case (state)
      IDLE: begin
        // An older pending sample always goes first; a simultaneous new one
        // takes its place in the skid register.
        if (pend_vld) begin
          wr_en     = 1'b1;
          wr_dat    = pend_dat;
          state_nxt = SEQ;
          if (smpl_vld) pend_load = 1'b1;
          else          pend_clr  = 1'b1;
        end else if (smpl_vld) begin
          wr_en     = 1'b1;
          state_nxt = SEQ;
        end
      end
      SEQ: begin
        // Address for tap k+1 goes out now; slots beyond fill read as zero.
        rd_en_nxt = (k < fill);
        if (k == K_LAST) state_nxt = END;
      end
      END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && smpl_vld) begin
      if (!pend_vld) pend_load = 1'b1;
      else           ovr_set   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      k        <= '0;
      pend_vld <= 1'b0;
      pend_dat <= '0;
      ovr      <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      rd_en_q <= rd_en_nxt;
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
      if (state == IDLE)     rd_ptr <= wr_ptr;
      else if (state == SEQ) rd_ptr <= (rd_ptr == '0) ? PTR_LAST : rd_ptr - 1'b1;
      if (state == SEQ && state_nxt == SEQ) k <= k + 1'b1;
      else                                  k <= '0;
      if (pend_load) begin
        pend_vld <= 1'b1;
        pend_dat <= smpl_wr;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
      if (ovr_set) ovr <= 1'b1;
    end
  end

  // History storage: no reset, synchronous read.
  always_ff @(posedge clk) begin
    if (wr_en)        mem[wr_ptr] <= wr_dat;
    if (state == SEQ) rd_q        <= mem[rd_ptr];
  end

  assign smpl_in    = rd_en_q ? rd_q : '0;
  assign sequencing = (state == SEQ);
  assign seq_done   = (state == END);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fir_smpl_seq.sv
// Scoreboard bench for fir_smpl_seq: the driver pushes the expected pass for
// each accepted sample, the monitor captures every pass and compares.
module tb_fir_smpl_seq;

  localparam int NT = 13;
  localparam int PW = 4;

  typedef logic [NT+1:0][15:0] pass_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               smpl_vld = 1'b0;
  logic signed [15:0] smpl_wr = '0;
  logic               sequencing;
  logic signed [15:0] smpl_in;
  logic               seq_done;
  logic               busy;
  logic               ovr;

  int n_vec = 0;
  int n_err = 0;

  pass_t       exp_q[$];
  logic [15:0] hist[$];
  pass_t       last_pass;

  fir_smpl_seq #(.NUM_TAPS(NT), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_wr(smpl_wr),
    .sequencing(sequencing), .smpl_in(smpl_in), .seq_done(seq_done),
    .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Model: the pass for a sample is the history after writing it, newest at k=1.
  task automatic accept(input logic [15:0] v);
    pass_t p;
    hist.push_front(v);
    if (hist.size() > NT) void'(hist.pop_back());
    p = '0;
    for (int i = 0; i < hist.size(); i++) p[i+1] = hist[i];
    exp_q.push_back(p);
  endtask

  task automatic send(input logic [15:0] v);
    smpl_vld = 1'b1;
    smpl_wr  = v;
    @(posedge clk); #1;
    smpl_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    hist.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got %0d passes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  // Monitor
  initial begin : monitor
    pass_t cur;
    pass_t e;
    int    kmon;
    kmon = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        kmon = 0;
      end else if (sequencing) begin
        if (kmon == 0) cur = '0;
        if (kmon < NT + 2) cur[kmon] = smpl_in;
        kmon++;
      end else if (kmon > 0) begin
        n_vec++;
        if (kmon != NT + 2) begin
          n_err++;
          $display("FAIL pass_len: got %0d cycles, expected %0d", kmon, NT + 2);
        end
        n_vec++;
        if (seq_done !== 1'b1) begin
          n_err++;
          $display("FAIL seq_done_after_pass: got %b, expected 1", seq_done);
        end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pass: got a pass, expected none");
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_err++;
            for (int i = 0; i < NT + 2; i++)
              if (cur[i] !== e[i]) begin
                $display("FAIL pass_data k=%0d: got %h, expected %h", i, cur[i], e[i]);
                break;
              end
          end
        end
        last_pass = cur;
        kmon = 0;
      end
    end
  end

  initial begin : driver
    int n;
    #2;
    // Reset state
    chk("rst_sequencing", {15'd0, sequencing}, 16'd0);
    chk("rst_smpl_in",    smpl_in,             16'd0);
    chk("rst_seq_done",   {15'd0, seq_done},   16'd0);
    chk("rst_busy",       {15'd0, busy},       16'd0);
    chk("rst_ovr",        {15'd0, ovr},        16'd0);
    do_reset();

    // Impulse: 0x7FFF followed by zeros walks out one tap per pass
    accept(16'h7FFF);
    send(16'h7FFF);
    chk("latency_sequencing", {15'd0, sequencing}, 16'd1);
    chk("latency_busy",       {15'd0, busy},       16'd1);
    chk("k0_smpl_in",         smpl_in,             16'd0);
    wait_quiet("impulse1");
    for (int i = 0; i < 3; i++) begin
      accept(16'h0000);
      send(16'h0000);
      wait_quiet("impulse_n");
    end
    chk("impulse_pass4_k4", last_pass[4], 16'h7FFF);

    // Partial fill
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      accept(16'(i));
      send(16'(i));
      wait_quiet("partial");
    end
    chk("partial_k1", last_pass[1], 16'd3);
    chk("partial_k3", last_pass[3], 16'd1);
    chk("partial_k4", last_pass[4], 16'd0);

    // Wrap-around: NT+4 samples, oldest surviving is 5
    do_reset();
    for (int i = 1; i <= NT + 4; i++) begin
      accept(16'(i));
      send(16'(i));
      wait_quiet("wrap");
    end
    chk("wrap_k1",  last_pass[1],  16'(NT + 4));
    chk("wrap_kNT", last_pass[NT], 16'd5);

    // Overrun: A pends, B and C are dropped
    do_reset();
    accept(16'h0100);
    send(16'h0100);
    repeat (3) @(posedge clk); #1;
    accept(16'h0A0A);
    send(16'h0A0A);
    chk("ovr_after_A", {15'd0, ovr}, 16'd0);
    repeat (2) @(posedge clk); #1;
    send(16'h0B0B);
    repeat (2) @(posedge clk); #1;
    send(16'h0C0C);
    chk("ovr_after_C", {15'd0, ovr}, 16'd1);
    wait_quiet("overrun");
    chk("ovr_sticky", {15'd0, ovr}, 16'd1);
    do_reset();
    chk("ovr_cleared", {15'd0, ovr}, 16'd0);

    // Reset mid-pass
    accept(16'h1111);
    send(16'h1111);
    wait_quiet("midrst_a");
    accept(16'h2222);
    send(16'h2222);
    wait_quiet("midrst_b");
    accept(16'h3333);
    send(16'h3333);
    repeat (7) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_sequencing", {15'd0, sequencing}, 16'd0);
    chk("midrst_busy",       {15'd0, busy},       16'd0);
    chk("midrst_smpl_in",    smpl_in,             16'd0);
    exp_q.delete();
    hist.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    accept(16'h4444);
    send(16'h4444);
    wait_quiet("midrst_after");
    chk("midrst_k1", last_pass[1], 16'h4444);
    chk("midrst_k2", last_pass[2], 16'h0000);

    // Simultaneous: new arrival in the IDLE cycle that consumes a pending one
    do_reset();
    accept(16'h0005);
    send(16'h0005);
    repeat (2) @(posedge clk); #1;
    accept(16'h0006);
    send(16'h0006);
    n = 0;
    while (!seq_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL simul_seq_done timeout: got no seq_done, expected one");
    end
    @(posedge clk); #1;
    accept(16'h0007);
    send(16'h0007);
    wait_quiet("simul");
    chk("simul_ovr", {15'd0, ovr}, 16'd0);
    chk("simul_k1",  last_pass[1], 16'h0007);
    chk("simul_k3",  last_pass[3], 16'h0005);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
